pcs_encoder_64b66b: RTL
=======================

# pcs_encoder_64b66b

- Second-generation 64b/66b PCS transmit encoder.
- Accepts XGMII columns 32 or 64 bits wide, gathers them into 64-bit blocks, and classifies each block into the Clause 49 block types.
- Emits 66-bit blocks on a ready/valid stream towards the gearbox; the stream holds a one-entry skid buffer.
- Sits between the MAC TX XGMII output and the PCS scrambler/gearbox. An optional built-in scrambler is available.

## Interface
- XGMII_DATA_WIDTH, 32: XGMII column width. Legal values are 32 and 64.
- XGMII_DATA_BYTES, XGMII_DATA_WIDTH/8: control bits per column.
- PCS_DATA_WIDTH, 66: encoded block width. Fixed at 66.
- ERR_CNT_WIDTH, 16: width of the saturating error counter.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-low reset.
- xgmii_data_in  in  XGMII_DATA_WIDTH  lane 0 = bits [7:0].
- xgmii_ctrl_in  in  XGMII_DATA_BYTES  1 = the lane carries a control character.
- xgmii_ready  out  1  a column is accepted on a cycle where xgmii_ready=1. There is no input valid; XGMII is continuous.
- encoded_data_out  out  66  [1:0] = sync header (bit 0 is first on the wire); [65:2] = payload.
- encoded_valid_out  out  1  block present.
- encoded_ready_in  in  1  downstream accepts the block when valid && ready.
- encode_error  out  1  one-cycle pulse when an error block is emitted.
- err_count  out  ERR_CNT_WIDTH  count of error blocks. Saturates at all-ones.

## Operation
- Column gathering:
  - Width 64: each accepted column is one block.
  - Width 32: the first accepted word fills lanes 0–3 and the second fills lanes 4–7.
  - A phase bit tracks which half is being filled. It toggles only on acceptance.
- Sync header: 2'b01 when all 8 ctrl bits = 0 (data block; payload = the 8 bytes, lane 0 at [9:2]). Otherwise 2'b10 (control block), with the block type in [9:2].
- Control character mapping, 8-bit to 7-bit: /I/ 0x07 → 0x00; /E/ 0xFE → 0x1E.
- Control block types:
  - 0x1E: all 8 lanes are /I/ or /E/.
  - 0x78: lane 0 = /S/ 0xFB, lanes 1–7 are data.
  - 0x33: lanes 0–3 are /I/, lane 4 = /S/, lanes 5–7 are data.
  - Terminate types 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF cover /T/ 0xFD in lanes 0 to 7 respectively:
    - lanes before /T/ are data;
    - lanes after /T/ must be /I/ and encode as 0x00.
- Any other pattern (stray /S/, /T/ followed by data, an unknown control character, or an ordered set) emits an error block:
  - block type 0x1E with all eight 7-bit codes = 0x1E;
  - encode_error pulses and err_count increments.
- Output stage: the output register plus a one-entry skid buffer.
  - xgmii_ready = skid empty.
  - If the output is stalled when a block completes, the block goes to the skid. Nothing is ever dropped.
- Reset asserted at any time:
  - phase := 0 and any partial half-block is discarded;
  - skid emptied;
  - encoded_valid_out := 0, encoded_data_out := 0;
  - encode_error := 0, err_count := 0;
  - xgmii_ready := 1 on the first clk edge after release.

## Timing
- Latency: the block appears on encoded_data_out one cycle after the column that completes it is accepted.
- encoded_data_out and encoded_valid_out are held stable while valid && !ready.
- Throughput at width 32: one block per two accepted words. Valid is deasserted between blocks unless backpressure has built up.
- Simultaneous events: output handshake plus a new block completing in the same cycle → the new block loads the output directly and the skid stays empty.
- Skid full means xgmii_ready=0. The upstream MAC must hold its column; no columns are lost.
- err_count and encode_error are registered in the same cycle the error block is loaded into the output register.

## Configuration
- PCS_ENCODER_SCRAMBLER_EN:
  - When defined, payload bits [65:2] pass through the self-synchronous scrambler x^58+x^39+1 before output. The sync header is not scrambled.
  - The state is 58 bits, reset to all-ones, and advances only on blocks loaded into the output register.
  - When not defined, the payload is output unscrambled and the scrambler logic is absent.

## Structure
- Shared package pcs_pkg holds:
  - block type constants: BT_C8 = 0x1E, BT_S0 = 0x78, BT_S4 = 0x33, BT_T0..BT_T7;
  - XGMII characters: 0x07, 0xFB, 0xFD, 0xFE;
  - 7-bit control codes;
  - sync header constants SH_DATA and SH_CTRL.
- One sub-module, pcs_scrambler_58: a 64-bit-parallel scrambler, instantiated only under the macro.

## Test plan
- Width 32, idle {4{0x07}} ctrl 4'b1111 ×2 → block 0x1E control, all codes 0x00, valid 1 cycle after the second word.
- Width 32, start frame:
  - stimulus: {55,55,55,FB} ctrl 0001, then {D5,55,55,55} ctrl 0000;
  - required: header 2'b10, [9:2] = 0x78, followed by data block 0x33221100/0xBBAA5544 with header 2'b01.
- Terminate {07,07,07,FD} ctrl 1111 in lanes 4–7 after data word 0x713B28B2 → type 0xCC, data bytes B2 28 3B 71, idle codes 0x00.
- /T/ in lane 2 followed by data in lane 3 → error block 0x1E/0x1E codes, encode_error pulse, err_count = 1.
- Hold encoded_ready_in = 0 for 6 cycles during a data stream:
  - xgmii_ready drops once the skid is full;
  - the output stays stable;
  - after release, blocks arrive in order with no loss or duplication.
- Assert rst mid-block (after the first half-word) → valid 0 immediately. After release, the next two words form a fresh block; the stale half does not appear.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS constants: sync headers, block types, XGMII characters, 7-bit codes.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package pcs_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam logic [7:0] BT_C8 = 8'h1E;
    localparam logic [7:0] BT_S0 = 8'h78;
    localparam logic [7:0] BT_S4 = 8'h33;
    localparam logic [7:0] BT_T0 = 8'h87;
    localparam logic [7:0] BT_T1 = 8'h99;
    localparam logic [7:0] BT_T2 = 8'hAA;
    localparam logic [7:0] BT_T3 = 8'hB4;
    localparam logic [7:0] BT_T4 = 8'hCC;
    localparam logic [7:0] BT_T5 = 8'hD2;
    localparam logic [7:0] BT_T6 = 8'hE1;
    localparam logic [7:0] BT_T7 = 8'hFF;

    localparam logic [7:0] XG_IDLE  = 8'h07;
    localparam logic [7:0] XG_START = 8'hFB;
    localparam logic [7:0] XG_TERM  = 8'hFD;
    localparam logic [7:0] XG_ERROR = 8'hFE;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    // Encoded block before scrambling, tagged with whether it is an error block.
    typedef struct packed {
        logic        err;
        logic [65:0] dat;
    } enc_blk_t;

    function automatic logic [7:0] term_type(input logic [2:0] lane);
        case (lane)
            3'd0:    term_type = BT_T0;
            3'd1:    term_type = BT_T1;
            3'd2:    term_type = BT_T2;
            3'd3:    term_type = BT_T3;
            3'd4:    term_type = BT_T4;
            3'd5:    term_type = BT_T5;
            3'd6:    term_type = BT_T6;
            default: term_type = BT_T7;
        endcase
    endfunction

endpackage

// File: rtl/pcs_scrambler_58.sv
// 64-bit-parallel self-synchronous scrambler, x^58 + x^39 + 1, state reset to all-ones.
// Latency: combinational dout; state updates on the clock edge when advance is high.
// Backpressure: none; the caller advances only on blocks it actually keeps.
module pcs_scrambler_58 (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic [63:0] din,
    output logic [63:0] dout
);

    logic [57:0] state;
    logic [57:0] state_nxt;

    // Bit 0 of din is transmitted first; history index 0 is the oldest scrambled bit.
    always_comb begin : p_scr
        logic [121:0] hist;
        hist = {64'h0, state};
        for (int i = 0; i < 64; i++) begin
            hist[58 + i] = din[i] ^ hist[i + 19] ^ hist[i];
        end
        dout      = hist[121:58];
        state_nxt = hist[121:64];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= '1;
        end else if (advance) begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/pcs_encoder_64b66b.sv
// 64b/66b PCS TX encoder: XGMII columns -> Clause 49 blocks; optional scrambler via PCS_ENCODER_SCRAMBLER_EN.
// Latency: block valid one cycle after its completing column is accepted.
// Backpressure: output register + one-entry skid; xgmii_ready drops while the skid is full.
module pcs_encoder_64b66b
    import pcs_pkg::*;
#(
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8,
    parameter int PCS_DATA_WIDTH   = 66,
    parameter int ERR_CNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [XGMII_DATA_WIDTH-1:0] xgmii_data_in,
    input  logic [XGMII_DATA_BYTES-1:0] xgmii_ctrl_in,
    output logic                        xgmii_ready,
    output logic [PCS_DATA_WIDTH-1:0]   encoded_data_out,
    output logic                        encoded_valid_out,
    input  logic                        encoded_ready_in,
    output logic                        encode_error,
    output logic [ERR_CNT_WIDTH-1:0]    err_count
);

    logic        accept;
    logic        col_vld;
    logic [63:0] col_dat;
    logic [7:0]  col_ctl;

    logic        skid_vld;
    enc_blk_t    skid_q;

    assign xgmii_ready = !skid_vld;
    assign accept      = xgmii_ready;

    generate
        if (XGMII_DATA_WIDTH == 64) begin : g_w64
            assign col_dat = xgmii_data_in;
            assign col_ctl = xgmii_ctrl_in;
            assign col_vld = accept;
        end else begin : g_w32
            logic        phase;
            logic [31:0] lo_dat;
            logic [3:0]  lo_ctl;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    phase  <= 1'b0;
                    lo_dat <= '0;
                    lo_ctl <= '0;
                end else if (accept) begin
                    phase <= !phase;
                    if (!phase) begin
                        lo_dat <= xgmii_data_in;
                        lo_ctl <= xgmii_ctrl_in;
                    end
                end
            end

            assign col_dat = {xgmii_data_in, lo_dat};
            assign col_ctl = {xgmii_ctrl_in, lo_ctl};
            assign col_vld = accept && phase;
        end
    endgenerate

    logic [7:0] is_idle;
    logic [7:0] is_err;

    always_comb begin
        is_idle = '0;
        is_err  = '0;
        for (int i = 0; i < 8; i++) begin
            is_idle[i] = col_ctl[i] && (col_dat[8*i +: 8] == XG_IDLE);
            is_err[i]  = col_ctl[i] && (col_dat[8*i +: 8] == XG_ERROR);
        end
    end

    // /T/ in lane k is legal only with data before it and /I/ after it.
    logic       t_hit;
    logic [2:0] t_lane;

    always_comb begin : p_term
        logic ok;
        t_hit  = 1'b0;
        t_lane = 3'd0;
        for (int k = 0; k < 8; k++) begin
            ok = col_ctl[k] && (col_dat[8*k +: 8] == XG_TERM);
            for (int j = 0; j < 8; j++) begin
                if (j < k && col_ctl[j]) begin
                    ok = 1'b0;
                end
                if (j > k && !is_idle[j]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                t_hit  = 1'b1;
                t_lane = 3'(k);
            end
        end
    end

    enc_blk_t blk_new;

    always_comb begin
        blk_new = '0;
        if (col_ctl == 8'h00) begin
            blk_new.dat = {col_dat, SH_DATA};
        end else begin
            blk_new.dat[1:0] = SH_CTRL;
            if (&(is_idle | is_err)) begin
                blk_new.dat[9:2] = BT_C8;
                for (int i = 0; i < 8; i++) begin
                    blk_new.dat[10 + 7*i +: 7] = is_idle[i] ? CC_IDLE : CC_ERROR;
                end
            end else if (col_ctl == 8'h01 && col_dat[7:0] == XG_START) begin
                blk_new.dat[9:2]   = BT_S0;
                blk_new.dat[65:10] = col_dat[63:8];
            end else if (col_ctl == 8'h1F && (&is_idle[3:0]) && col_dat[39:32] == XG_START) begin
                // Idle codes C0..C3 and the 4-bit pad stay zero.
                blk_new.dat[9:2]   = BT_S4;
                blk_new.dat[65:42] = col_dat[63:40];
            end else if (t_hit) begin
                blk_new.dat[9:2] = term_type(t_lane);
                for (int i = 0; i < 7; i++) begin
                    if (3'(i) < t_lane) begin
                        blk_new.dat[10 + 8*i +: 8] = col_dat[8*i +: 8];
                    end
                end
            end else begin
                blk_new.err      = 1'b1;
                blk_new.dat[9:2] = BT_C8;
                for (int i = 0; i < 8; i++) begin
                    blk_new.dat[10 + 7*i +: 7] = CC_ERROR;
                end
            end
        end
    end

    logic        out_free;
    logic        load;
    enc_blk_t    load_blk;
    logic [63:0] load_payload;

    assign out_free = !encoded_valid_out || encoded_ready_in;
    assign load     = out_free && (skid_vld || col_vld);
    assign load_blk = skid_vld ? skid_q : blk_new;

`ifdef PCS_ENCODER_SCRAMBLER_EN
    pcs_scrambler_58 u_scrambler (
        .clk     (clk),
        .rst     (rst),
        .advance (load),
        .din     (load_blk.dat[65:2]),
        .dout    (load_payload)
    );
`else
    assign load_payload = load_blk.dat[65:2];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            encoded_valid_out <= 1'b0;
            encoded_data_out  <= '0;
            skid_vld          <= 1'b0;
            skid_q            <= '0;
            encode_error      <= 1'b0;
            err_count         <= '0;
        end else begin
            if (out_free) begin
                encoded_valid_out <= skid_vld || col_vld;
                skid_vld          <= 1'b0;
                if (load) begin
                    encoded_data_out <= {load_payload, load_blk.dat[1:0]};
                end
            end else if (col_vld) begin
                skid_vld <= 1'b1;
                skid_q   <= blk_new;
            end
            encode_error <= load && load_blk.err;
            if (load && load_blk.err && err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule
